// File: rtl/xctcmsg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xctcmsg_pkg : shared message types and send-arbiter constants        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package xctcmsg_pkg;

  typedef struct packed {
    logic [7:0]  dst;
    logic [31:0] payload;
  } send_queue_data_t;

  localparam int SEND_ARBITER_NUM_REQ = 2;
  localparam int SEND_ARBITER_CREDITS = 4;

  typedef logic [$clog2(SEND_ARBITER_NUM_REQ)-1:0] send_arbiter_id_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } send_arbiter_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_select : combinational round-robin search from a start pointer    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module rr_select #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int w_j;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      w_j = int'(i_ptr) + off;
      if (w_j >= N) w_j = w_j - N;
      if (i_elig[w_j]) begin
        o_found = 1'b1;
        o_idx   = IW'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/send_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | send_arbiter : credit-limited round-robin share of the send port     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module send_arbiter
  import xctcmsg_pkg::*;
#(
  parameter  int NUM_REQ = SEND_ARBITER_NUM_REQ,
  parameter  int CREDITS = SEND_ARBITER_CREDITS,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 send_queue_arbiter_valid,
  output logic [NUM_REQ-1:0]                 arbiter_send_queue_ready,
  input  send_queue_data_t [NUM_REQ-1:0]     send_queue_arbiter_data,
  output logic                               arbiter_postoffice_valid,
  input  logic                               postoffice_arbiter_ready,
  output send_queue_data_t                   arbiter_postoffice_data,
  output logic [IDW-1:0]                     arbiter_postoffice_id,
  input  logic                               postoffice_credit_valid,
  input  logic [IDW-1:0]                     postoffice_credit_id,
  output logic                               credit_overflow
);

  send_arbiter_state_t r_state;
  logic [IDW-1:0]      r_grant_q;
  logic [IDW-1:0]      r_rr_ptr;
  logic                r_overflow;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_ovf;
  logic                w_found;
  logic [IDW-1:0]      w_sel_idx;
  logic [IDW-1:0]      w_gidx;
  logic [IDW-1:0]      w_ptr_next;
  logic                w_valid;
  logic                w_xfer;

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_sel_idx)
  );

  // Valid depends only on state and eligibility, never on the downstream ready.
  assign w_gidx     = (r_state == ARB_LOCKED) ? r_grant_q : w_sel_idx;
  assign w_valid    = (r_state == ARB_LOCKED) | w_found;
  assign w_xfer     = w_valid & postoffice_arbiter_ready;
  assign w_ptr_next = (w_gidx == IDW'(NUM_REQ - 1)) ? '0 : w_gidx + IDW'(1);

  assign arbiter_postoffice_valid = w_valid;
  assign arbiter_postoffice_id    = w_gidx;
  assign arbiter_postoffice_data  = send_queue_arbiter_data[w_gidx];
  assign credit_overflow          = r_overflow;

  always_comb begin
    arbiter_send_queue_ready         = '0;
    arbiter_send_queue_ready[w_gidx] = w_xfer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_grant_q <= '0;
      r_rr_ptr  <= '0;
    end else begin
      if (w_xfer) r_rr_ptr <= w_ptr_next;
      case (r_state)
        ARB_IDLE: begin
          if (w_found && !postoffice_arbiter_ready) begin
            r_state   <= ARB_LOCKED;
            r_grant_q <= w_sel_idx;
          end
        end
        ARB_LOCKED: begin
          if (w_xfer) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (flush) begin
        r_state  <= ARB_IDLE;
        r_rr_ptr <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_credit
    logic [CW-1:0] r_cnt;
    logic          w_dec;
    logic          w_inc;

    assign w_dec      = w_xfer && (w_gidx == IDW'(gi));
    assign w_inc      = postoffice_credit_valid && (postoffice_credit_id == IDW'(gi));
    assign w_elig[gi] = send_queue_arbiter_valid[gi] && (r_cnt != '0);
    assign w_ovf[gi]  = w_inc && !w_dec && (r_cnt == CW'(CREDITS));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= CW'(CREDITS);
      end else if (w_inc && !w_dec && !w_ovf[gi]) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= r_overflow | (|w_ovf);
  end

endmodule
`default_nettype wire

// File: tb/tb_send_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_send_arbiter : directed self-checking bench for send_arbiter      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_send_arbiter;
  import xctcmsg_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic [1:0]             sq_valid = 2'b00;
  logic [1:0]             sq_ready;
  send_queue_data_t [1:0] sq_data;
  logic                   po_valid;
  logic                   po_ready = 1'b0;
  send_queue_data_t       po_data;
  logic [0:0]             po_id;
  logic                   cr_valid = 1'b0;
  logic [0:0]             cr_id = 1'b0;
  logic                   ovf;

  int n_cmp = 0;
  int n_err = 0;

  send_queue_data_t c_d0, c_d1;
  logic [0:0]       exp_id;
  logic [3:0]       exp_out;

  always #5 clk = ~clk;

  send_arbiter #(.NUM_REQ(2), .CREDITS(4)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .flush                    (flush),
    .send_queue_arbiter_valid (sq_valid),
    .arbiter_send_queue_ready (sq_ready),
    .send_queue_arbiter_data  (sq_data),
    .arbiter_postoffice_valid (po_valid),
    .postoffice_arbiter_ready (po_ready),
    .arbiter_postoffice_data  (po_data),
    .arbiter_postoffice_id    (po_id),
    .postoffice_credit_valid  (cr_valid),
    .postoffice_credit_id     (cr_id),
    .credit_overflow          (ovf)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({po_valid, sq_ready, ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold got %b want 0000", {po_valid, sq_ready, ovf});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    n_cmp++;
    if ({po_valid, sq_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got %b want 000", {po_valid, sq_ready});
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) begin
      sq_valid = 2'b11;
      po_ready = 1'b1;
      cr_valid = (k > 0);
      cr_id    = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      exp_id  = (k % 2 == 1) ? 1'b1 : 1'b0;
      exp_out = exp_id ? 4'b1110 : 4'b1001;
      n_cmp++;
      if ({po_valid, po_id, sq_ready} !== exp_out) begin
        n_err++;
        $display("FAIL rr_out k=%0d got %b want %b", k, {po_valid, po_id, sq_ready}, exp_out);
      end
      n_cmp++;
      if (po_data !== (exp_id ? c_d1 : c_d0)) begin
        n_err++;
        $display("FAIL rr_data k=%0d got %h want %h", k, po_data, exp_id ? c_d1 : c_d0);
      end
      cyc();
    end
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b1;
    cr_id    = 1'b1;
    cyc();
    cr_valid = 1'b0;
  endtask

  task automatic test_lock_hold();
    sq_valid = 2'b10;
    po_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) sq_valid = 2'b11;
      #1;
      n_cmp++;
      if ({po_valid, po_id, sq_ready} !== 4'b1100) begin
        n_err++;
        $display("FAIL lock_out k=%0d got %b want 1100", k, {po_valid, po_id, sq_ready});
      end
      n_cmp++;
      if (po_data !== c_d1) begin
        n_err++;
        $display("FAIL lock_data k=%0d got %h want %h", k, po_data, c_d1);
      end
      cyc();
    end
    po_ready = 1'b1;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1110) begin
      n_err++;
      $display("FAIL lock_release got %b want 1110", {po_valid, po_id, sq_ready});
    end
    cyc();
    sq_valid = 2'b01;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL lock_next got %b want 1001", {po_valid, po_id, sq_ready});
    end
    cyc();
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b1;
    cr_id    = 1'b1;
    cyc();
    cr_id = 1'b0;
    cyc();
    cr_valid = 1'b0;
  endtask

  task automatic test_credit_exhaustion();
    sq_valid = 2'b01;
    po_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({po_valid, po_id, sq_ready} !== 4'b1001) begin
        n_err++;
        $display("FAIL exh_send k=%0d got %b want 1001", k, {po_valid, po_id, sq_ready});
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      cr_valid = (k == 1);
      cr_id    = 1'b0;
      #1;
      n_cmp++;
      if ({po_valid, sq_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL exh_empty k=%0d got %b want 000", k, {po_valid, sq_ready});
      end
      cyc();
    end
    cr_valid = 1'b0;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL exh_refill got %b want 1001", {po_valid, po_id, sq_ready});
    end
    cyc();
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b1;
    cr_id    = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    cr_valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    sq_valid = 2'b01;
    po_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cr_valid = (k == 2);
      cr_id    = 1'b0;
      exp_out  = (k < 5) ? 4'b1001 : 4'b0000;
      #1;
      n_cmp++;
      if ({po_valid, sq_ready} !== {exp_out[3], exp_out[1:0]}) begin
        n_err++;
        $display("FAIL simul_send k=%0d got %b want %b", k, {po_valid, sq_ready},
                 {exp_out[3], exp_out[1:0]});
      end
      cyc();
    end
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL simul_no_ovf got %b want 0", ovf);
    end
    cr_valid = 1'b1;
    cr_id    = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    cr_id = 1'b1;
    cyc();
    cr_valid = 1'b0;
    #1;
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set got %b want 1", ovf);
    end
    sq_valid = 2'b10;
    po_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({po_valid, sq_ready} !== ((k < 4) ? 3'b110 : 3'b000)) begin
        n_err++;
        $display("FAIL ovf_cnt k=%0d got %b want %b", k, {po_valid, sq_ready},
                 (k < 4) ? 3'b110 : 3'b000);
      end
      cyc();
    end
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky got %b want 1", ovf);
    end
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b1;
    cr_id    = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    cr_valid = 1'b0;
  endtask

  task automatic test_flush();
    sq_valid = 2'b01;
    po_ready = 1'b1;
    cyc();
    sq_valid = 2'b10;
    po_ready = 1'b0;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1100) begin
      n_err++;
      $display("FAIL flush_lock got %b want 1100", {po_valid, po_id, sq_ready});
    end
    cyc();
    sq_valid = 2'b11;
    flush    = 1'b1;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1100) begin
      n_err++;
      $display("FAIL flush_cycle got %b want 1100", {po_valid, po_id, sq_ready});
    end
    cyc();
    flush    = 1'b0;
    po_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_out = (k == 0) ? 4'b1001 : 4'b1110;
      #1;
      n_cmp++;
      if ({po_valid, po_id, sq_ready} !== exp_out) begin
        n_err++;
        $display("FAIL flush_after k=%0d got %b want %b", k, {po_valid, po_id, sq_ready}, exp_out);
      end
      cyc();
    end
    sq_valid = 2'b00;
    po_ready = 1'b0;
    cr_valid = 1'b1;
    cr_id    = 1'b0;
    cyc();
    cyc();
    cr_id = 1'b1;
    cyc();
    cr_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    sq_valid = 2'b01;
    po_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    sq_valid = 2'b11;
    po_ready = 1'b0;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1100) begin
      n_err++;
      $display("FAIL arst_pre got %b want 1100", {po_valid, po_id, sq_ready});
    end
    cyc();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL arst_state got %b want 1000", {po_valid, po_id, sq_ready});
    end
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL arst_ovf got %b want 0", ovf);
    end
    sq_valid = 2'b00;
    #1;
    n_cmp++;
    if ({po_valid, sq_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL arst_idle got %b want 000", {po_valid, sq_ready});
    end
    #1 rst_n = 1'b1;
    cyc();
    sq_valid = 2'b01;
    po_ready = 1'b1;
    #1;
    n_cmp++;
    if ({po_valid, po_id, sq_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL arst_resume got %b want 1001", {po_valid, po_id, sq_ready});
    end
    cyc();
    sq_valid = 2'b00;
    po_ready = 1'b0;
  endtask

  initial begin
    c_d0       = '{dst: 8'h10, payload: 32'hA0A0_0001};
    c_d1       = '{dst: 8'h21, payload: 32'hB1B1_0002};
    sq_data[0] = c_d0;
    sq_data[1] = c_d1;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_credit_exhaustion();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
